// File: rtl/tick_timer_ctrl.sv
// Tick-driven timer: counts a loaded number of upstream tick strobes and pulses on expiry.
// One-shot and periodic modes, with pause and abort; every output comes from a register.
module tick_timer_ctrl #(
    parameter int unsigned PERIOD_W  = 8,
    parameter int unsigned EXP_CNT_W = 4
) (
    input  logic                 clkIn,
    input  logic                 rstNIn,
    input  logic                 tickIn,
    input  logic                 startIn,
    input  logic [PERIOD_W-1:0]  periodIn,
    input  logic                 modeIn,
    input  logic                 pauseIn,
    input  logic                 stopIn,
    output logic                 busyOut,
    output logic                 expireOut,
    output logic                 doneOut,
    output logic                 errOut,
    output logic [PERIOD_W-1:0]  remainOut,
    output logic [EXP_CNT_W-1:0] expCntOut
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e               stateQ, stateD;
    logic [PERIOD_W-1:0]  remainQ, remainD;
    logic [PERIOD_W-1:0]  periodQ, periodD;
    logic                 modeQ, modeD;
    logic [EXP_CNT_W-1:0] expCntQ, expCntD;
    logic                 expireQ, expireD;
    logic                 errQ, errD;
    logic                 busyQ, busyD;
    logic                 doneQ, doneD;

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            stateQ  <= StIdle;
            remainQ <= '0;
            periodQ <= '0;
            modeQ   <= 1'b0;
            expCntQ <= '0;
            expireQ <= 1'b0;
            errQ    <= 1'b0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            remainQ <= remainD;
            periodQ <= periodD;
            modeQ   <= modeD;
            expCntQ <= expCntD;
            expireQ <= expireD;
            errQ    <= errD;
            busyQ   <= busyD;
            doneQ   <= doneD;
        end
    end

    // Priority: stop > start > pause > tick.
    always_comb begin
        stateD  = stateQ;
        remainD = remainQ;
        periodD = periodQ;
        modeD   = modeQ;
        expCntD = expCntQ;
        expireD = 1'b0;
        errD    = 1'b0;
        if (stopIn) begin
            stateD  = StIdle;
            remainD = '0;
        end else if (startIn) begin
            if (periodIn != '0) begin
                periodD = periodIn;
                modeD   = modeIn;
                remainD = periodIn;
                expCntD = '0;
                stateD  = StRun;
            end else begin
                errD = 1'b1;
            end
        end else begin
            unique case (stateQ)
                StRun: begin
                    if (pauseIn) begin
                        stateD = StPause;
                    end else if (tickIn) begin
                        if (remainQ > PERIOD_W'(1)) begin
                            remainD = remainQ - PERIOD_W'(1);
                        end else if (remainQ == PERIOD_W'(1)) begin
                            expireD = 1'b1;
                            if (expCntQ != '1) begin
                                expCntD = expCntQ + EXP_CNT_W'(1);
                            end
                            if (modeQ) begin
                                remainD = periodQ;
                            end else begin
                                remainD = '0;
                                stateD  = StDone;
                            end
                        end
                    end
                end
                StPause: begin
                    if (!pauseIn) begin
                        stateD = StRun;
                    end
                end
                default: ;
            endcase
        end
        busyD = (stateD == StRun) || (stateD == StPause);
        doneD = (stateD == StDone);
    end

    always_comb begin
        busyOut   = busyQ;
        expireOut = expireQ;
        doneOut   = doneQ;
        errOut    = errQ;
        remainOut = remainQ;
        expCntOut = expCntQ;
    end

endmodule
